cam_config_sequencer: RTL and testbench
=======================================

# cam_config_sequencer

Sequences camera register configuration at power-up: walks a register/value table held in an external synchronous ROM and issues one SCCB write command per entry to the SCCB master. The SCCB master runs from the 200 kHz SCCB clock enable. The block handles table markers for delays and end-of-table, retries NACKed writes, and reports completion or failure to the top-level capture pipeline, which must not start until `done_o` is set.

## Interface
- `ROM_AW`, 8: ROM address width; the table depth is 2^ROM_AW entries.
- `DELAY_CYCLES`, 1_000_000: length of a delay-marker wait in `clk_i` cycles (10 ms at 100 MHz).
- `MAX_RETRIES`, 3: retries allowed per entry after a NACK before the error state.

Ports:
- `clk_i` in 1: system clock, 100 MHz.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: single-cycle pulse that begins a configuration pass.
- `rom_addr_o` out ROM_AW: table index being read.
- `rom_data_i` in 16: table entry {reg[15:8], val[7:0]}, valid one cycle after `rom_addr_o`.
- `cmd_valid_o` out 1: write command valid.
- `cmd_ready_i` in 1: SCCB master accepts the command.
- `cmd_reg_o` out 8: register address of the command.
- `cmd_val_o` out 8: register value of the command.
- `wr_done_i` in 1: single-cycle pulse marking the end of the SCCB write.
- `wr_nack_i` in 1: qualifies `wr_done_i`; the slave NACKed.
- `busy_o` out 1: a pass is in progress.
- `done_o` out 1: level; the pass completed successfully.
- `error_o` out 1: level; the pass aborted after the retries were exhausted.
- `index_o` out ROM_AW: current or failing table index.

## Operation
- Entry decode: 16'hFFFF is end of table (END). 16'hFFF0 is a delay marker (DLY). Every other value is a write of {reg, val}.
- States:
  - IDLE: on `start_i`, index←0, clear `done_o`/`error_o`, go to FETCH.
  - FETCH: drive `rom_addr_o`=index for one cycle, go to DECODE.
  - DECODE: sample `rom_data_i`. END→DONE. DLY→DELAY with the counter loaded to DELAY_CYCLES-1. Otherwise latch reg/val, retry count←0, go to ISSUE.
  - ISSUE: hold `cmd_valid_o`=1 with `cmd_reg_o`/`cmd_val_o` stable. On `cmd_valid_o`&&`cmd_ready_i`, go to WAIT_DONE.
  - WAIT_DONE: on `wr_done_i`:
    - `wr_nack_i`=0: advance.
    - `wr_nack_i`=1 and retries<MAX_RETRIES: retries+1, go to ISSUE.
    - Otherwise go to ERROR.
  - DELAY: decrement each cycle; when the counter reaches 0, advance.
  - Advance: if index==2^ROM_AW-1, go to DONE (no wrap). Else index+1, go to FETCH.
  - DONE: `done_o`=1. ERROR: `error_o`=1, `index_o` frozen at the failing entry. Both states accept `start_i` to restart a pass from index 0.
- `busy_o`=1 in every state except IDLE, DONE and ERROR.
- `start_i` is ignored while `busy_o`=1.
- `wr_done_i` outside WAIT_DONE is ignored. `cmd_ready_i` outside ISSUE is ignored.
- Counter widths: retry counter is $clog2(MAX_RETRIES+1); delay counter is $clog2(DELAY_CYCLES+1). Neither counter may wrap.

## Timing
- Reset: the following outputs are 0 and the state is IDLE, asynchronously on `reset_i` assertion: `rom_addr_o`, `cmd_valid_o`, `cmd_reg_o`, `cmd_val_o`, `busy_o`, `done_o`, `error_o`, `index_o`. Reset mid-pass drops `cmd_valid_o` immediately and abandons the pass; no resume.
- All outputs are registered.
- `start_i` at edge N: FETCH at N+1, DECODE at N+2, `cmd_valid_o` high at N+3 for a write entry.
- `cmd_valid_o` falls in the cycle after the handshake. The payload never changes while `cmd_valid_o`=1.
- Entry-to-entry overhead after `wr_done_i`: 3 cycles to the next `cmd_valid_o` (WAIT_DONE→FETCH→DECODE→ISSUE).
- A DLY entry occupies exactly DELAY_CYCLES cycles in DELAY, then 2 cycles to the next ISSUE.
- A retry re-asserts `cmd_valid_o` in the cycle after the NACKed `wr_done_i`, with an identical payload.
- `done_o`/`error_o` assert in the cycle after the terminating decision and hold until the next accepted `start_i` or a reset.

## Test plan
- ROM {0x1280, 0x1101, 0xFFFF}, `cmd_ready_i` tied 1, `wr_done_i` 5 cycles after each accept: exactly two commands, (0x12,0x80) then (0x11,0x01). `done_o`=1, `busy_o`=0, `error_o`=0.
- ROM {0xFFF0, 0x1204, 0xFFFF} with DELAY_CYCLES=20: the first `cmd_valid_o` appears exactly 20+2 cycles after DELAY entry. Payload (0x12,0x04).
- `cmd_ready_i` held low for 7 cycles on an entry: `cmd_valid_o` and the payload stay stable for all 7 cycles. A single accept occurs; no duplicate command.
- Entry 1 NACKed twice then ACKed, MAX_RETRIES=3: 3 issues of the same payload, then the pass completes with `done_o`=1. NACKed 4 times: `error_o`=1, `index_o`=1, `done_o`=0.
- Assert `reset_i` while in WAIT_DONE: all outputs are 0 in the same cycle. After release, a `start_i` pulse restarts from `rom_addr_o`=0. `start_i` pulsed while busy: no effect on the sequence.
- ROM with no END marker and ROM_AW=2: 4 writes, then `done_o`=1; `rom_addr_o` never returns to 0.

Source files
------------

// File: rtl/cam_config_sequencer.sv
// Power-up camera register loader: walks a {reg,val} ROM table and issues
// one SCCB write per entry, with delay markers, end marker and NACK retries.
module cam_config_sequencer #(
   parameter int ROM_AW       = 8,
   parameter int DELAY_CYCLES = 1_000_000,
   parameter int MAX_RETRIES  = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [15:0]       rom_data_i,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic [7:0]        cmd_reg_o,
   output logic [7:0]        cmd_val_o,
   input  logic              wr_done_i,
   input  logic              wr_nack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ROM_AW-1:0] index_o
);

   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int DW = $clog2(DELAY_CYCLES + 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
   localparam logic [DW-1:0] DLY_LOAD  = DW'(DELAY_CYCLES - 1);
   localparam logic [15:0]   END_MARK  = 16'hFFFF;
   localparam logic [15:0]   DLY_MARK  = 16'hFFF0;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE,
      S_WAIT, S_DELAY, S_DONE, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [ROM_AW-1:0] index_q, index_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [DW-1:0]     dcnt_q, dcnt_d;
   logic [7:0]        reg_q, reg_d;
   logic [7:0]        val_q, val_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              adv;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         index_q <= '0;
         retry_q <= '0;
         dcnt_q  <= '0;
         reg_q   <= '0;
         val_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         retry_q <= retry_d;
         dcnt_q  <= dcnt_d;
         reg_q   <= reg_d;
         val_q   <= val_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      retry_d = retry_q;
      dcnt_d  = dcnt_q;
      reg_d   = reg_q;
      val_d   = val_q;
      adv     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               index_d = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (rom_data_i == END_MARK) begin
               state_d = S_DONE;
            end else if (rom_data_i == DLY_MARK) begin
               dcnt_d  = DLY_LOAD;
               state_d = S_DELAY;
            end else begin
               reg_d   = rom_data_i[15:8];
               val_d   = rom_data_i[7:0];
               retry_d = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (valid_q && cmd_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wr_done_i) begin
               if (!wr_nack_i) begin
                  adv = 1'b1;
               end else if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
         S_DELAY: begin
            if (dcnt_q == '0) adv = 1'b1;
            else dcnt_d = dcnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // The table never wraps: the last slot ends the pass like an END marker.
      if (adv) begin
         if (index_q == '1) begin
            state_d = S_DONE;
         end else begin
            index_d = index_q + 1'b1;
            state_d = S_FETCH;
         end
      end
   end

   // Outputs are registered copies of the next-state decode.
   always_comb begin
      valid_d = (state_d == S_ISSUE);
      done_d  = (state_d == S_DONE);
      error_d = (state_d == S_ERROR);
      busy_d  = !(state_d == S_IDLE || state_d == S_DONE ||
                  state_d == S_ERROR);
   end

   assign rom_addr_o  = index_q;
   assign index_o     = index_q;
   assign cmd_valid_o = valid_q;
   assign cmd_reg_o   = reg_q;
   assign cmd_val_o   = val_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Bench for cam_config_sequencer: table vectors, timing sequences and
// randomized passes against a table-walking reference model.
module tb_cam_config_sequencer;

   localparam int AW   = 2;
   localparam int DLY  = 20;
   localparam int MAXR = 3;
   localparam int LIM  = 3000;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_data;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [7:0]    cmd_reg;
   logic [7:0]    cmd_val;
   logic          wr_done;
   logic          wr_nack;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW-1:0] index;

   cam_config_sequencer #(
      .ROM_AW(AW), .DELAY_CYCLES(DLY), .MAX_RETRIES(MAXR)
   ) dut (
      .clk_i(clk), .reset_i(rst), .start_i(start),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data),
      .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
      .cmd_reg_o(cmd_reg), .cmd_val_o(cmd_val),
      .wr_done_i(wr_done), .wr_nack_i(wr_nack),
      .busy_o(busy), .done_o(done), .error_o(error), .index_o(index)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [4];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          st_cyc;
   int          first_addr;
   logic [15:0] nack_plan;
   int          done_n, hold, lat, dcnt;
   logic [15:0] log_q [$];
   int          rise_q [$];
   int          done_q [$];
   logic        nk_q [$];
   int          high_cnt, stab_err, wrap_seen;
   logic        prev_valid, saw_nz;
   logic [15:0] prev_pay;
   logic [15:0] exp_q [$];
   int          exp_done, exp_err, exp_idx;

   typedef struct {
      logic [63:0] tbl;
      logic [15:0] nk;
      int          hold;
      int          lat;
      int          ncmd;
      int          dn;
      int          er;
      int          idx;
   } vec_t;
   vec_t vt [8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // One clock of the SCCB master model: sample at negedge, drive inputs.
   task automatic tick();
      @(negedge clk);
      cyc++;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            wr_done = 1'b1;
            wr_nack = (done_n < 16) ? nack_plan[done_n] : 1'b0;
            done_n++;
            done_q.push_back(cyc);
            nk_q.push_back(wr_nack);
         end
      end
      if (cmd_valid) begin
         high_cnt++;
         if (prev_valid && {cmd_reg, cmd_val} != prev_pay) stab_err++;
         if (!prev_valid) rise_q.push_back(cyc);
      end
      if (busy && rom_addr != '0) saw_nz = 1'b1;
      if (busy && saw_nz && rom_addr == '0) wrap_seen++;
      if (cmd_valid && hold > 0) begin
         cmd_ready = 1'b0;
         hold--;
      end else begin
         cmd_ready = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
         log_q.push_back({cmd_reg, cmd_val});
         dcnt = lat;
      end
      prev_valid = cmd_valid;
      prev_pay   = {cmd_reg, cmd_val};
   endtask

   task automatic setup(input logic [63:0] tbl, input logic [15:0] nk,
                        input int h, input int l);
      for (int i = 0; i < 4; i++) rom[i] = tbl[63-16*i -: 16];
      nack_plan = nk;
      done_n = 0;
      hold = h;
      lat = l;
      log_q.delete();
      rise_q.delete();
      done_q.delete();
      nk_q.delete();
      high_cnt = 0;
      stab_err = 0;
      wrap_seen = 0;
      saw_nz = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      st_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end();
      int t = 0;
      while (!(done || error) && t < LIM) begin
         tick();
         t++;
      end
      if (t >= LIM) begin
         n_vec++;
         n_bad++;
         $display("FAIL timeout: no done/error after %0d cycles", t);
      end
   endtask

   task automatic run_pass(input logic [63:0] tbl, input logic [15:0] nk,
                           input int h, input int l);
      setup(tbl, nk, h, l);
      pulse_start();
      first_addr = int'(rom_addr);
      wait_end();
   endtask

   // Reference: walk the table entry by entry, attempts per write bounded.
   task automatic model();
      int k;
      int att;
      bit acked;
      exp_q.delete();
      k = 0;
      exp_done = 1;
      exp_err = 0;
      exp_idx = 3;
      for (int i = 0; i < 4; i++) begin
         if (rom[i] == 16'hFFFF) begin
            exp_idx = i;
            return;
         end
         if (rom[i] == 16'hFFF0) continue;
         att = 0;
         acked = 1'b0;
         while (!acked && att <= MAXR) begin
            exp_q.push_back(rom[i]);
            if (!((k < 16) ? nack_plan[k] : 1'b0)) acked = 1'b1;
            k++;
            att++;
         end
         if (!acked) begin
            exp_done = 0;
            exp_err = 1;
            exp_idx = i;
            return;
         end
      end
   endtask

   task automatic compare_pass(input string tag);
      model();
      chk({tag, ".ncmds"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s.cmd%0d", tag, i), log_q[i], exp_q[i]);
      chk({tag, ".done"}, done, exp_done);
      chk({tag, ".error"}, error, exp_err);
      chk({tag, ".index"}, index, exp_idx);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".stable"}, stab_err, 0);
      chk({tag, ".nowrap"}, wrap_seen, 0);
   endtask

   initial begin
      logic [15:0] e;
      logic [63:0] tbl;
      int t;
      rst = 1'b1;
      start = 1'b0;
      cmd_ready = 1'b1;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      dcnt = 0;
      prev_valid = 1'b0;
      prev_pay = '0;
      setup(64'hFFFF_FFFF_FFFF_FFFF, '0, 0, 1);
      #1;
      chk("reset.outs", {rom_addr, cmd_valid, cmd_reg, cmd_val, busy,
                         done, error, index}, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("idle.busy", busy, 0);

      vt[0] = '{64'h1280_1101_FFFF_0000, 16'h0000, 0, 5, 2, 1, 0, 2};
      vt[1] = '{64'hFFF0_1204_FFFF_0000, 16'h0000, 0, 3, 1, 1, 0, 2};
      vt[2] = '{64'h1280_1101_FFFF_0000, 16'h0006, 0, 2, 4, 1, 0, 2};
      vt[3] = '{64'h1280_1101_FFFF_0000, 16'h001E, 0, 2, 5, 0, 1, 1};
      vt[4] = '{64'h1111_2222_3333_4444, 16'h0000, 1, 1, 4, 1, 0, 3};
      vt[5] = '{64'h1280_FFFF_0000_0000, 16'h0007, 2, 4, 4, 1, 0, 1};
      vt[6] = '{64'hFFFF_1234_5678_9ABC, 16'h0000, 0, 1, 0, 1, 0, 0};
      vt[7] = '{64'h1280_FFFF_0000_0000, 16'h000F, 0, 3, 4, 0, 1, 0};
      for (int v = 0; v < 8; v++) begin
         run_pass(vt[v].tbl, vt[v].nk, vt[v].hold, vt[v].lat);
         chk($sformatf("vt%0d.ncmd", v), log_q.size(), vt[v].ncmd);
         chk($sformatf("vt%0d.done", v), done, vt[v].dn);
         chk($sformatf("vt%0d.err", v), error, vt[v].er);
         chk($sformatf("vt%0d.idx", v), index, vt[v].idx);
         compare_pass($sformatf("vt%0d", v));
         tick();
      end

      run_pass(vt[0].tbl, 16'h0000, 0, 5);
      chk("lat.start", rise_q[0] - st_cyc, 3);
      chk("lat.next", rise_q[1] - done_q[0], 3);
      chk("lat.addr0", first_addr, 0);

      run_pass(vt[1].tbl, 16'h0000, 0, 3);
      chk("dly.first", rise_q[0] - st_cyc, 3 + DLY + 2);
      chk("dly.pay", log_q[0], 16'h1204);

      run_pass(vt[2].tbl, 16'h0006, 0, 2);
      chk("retry.gap1", rise_q[2] - done_q[1], 1);
      chk("retry.gap2", rise_q[3] - done_q[2], 1);
      chk("retry.pay", log_q[3], log_q[1]);

      run_pass(vt[0].tbl, 16'h0000, 7, 5);
      chk("hold.high", high_cnt, 9);
      chk("hold.stable", stab_err, 0);
      chk("hold.ncmd", log_q.size(), 2);

      setup(vt[0].tbl, 16'h0000, 0, 40);
      pulse_start();
      t = 0;
      while (log_q.size() < 1 && t < 200) begin
         tick();
         t++;
      end
      tick();
      tick();
      chk("rst.pre_valid", cmd_valid, 0);
      chk("rst.pre_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst.async", {rom_addr, cmd_valid, cmd_reg, cmd_val, busy,
                        done, error, index}, 0);
      dcnt = 0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst.idle", busy, 0);
      run_pass(vt[0].tbl, 16'h0000, 0, 5);
      chk("rst.restart_addr", first_addr, 0);
      compare_pass("rst.pass");

      setup(vt[0].tbl, 16'h0000, 0, 5);
      pulse_start();
      t = 0;
      while (log_q.size() < 1 && t < 200) begin
         tick();
         t++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_end();
      compare_pass("busy_start");

      for (int p = 0; p < 40; p++) begin
         for (int i = 0; i < 4; i++) begin
            t = int'($urandom_range(0, 9));
            if (t == 0) e = 16'hFFFF;
            else if (t == 1) e = 16'hFFF0;
            else begin
               e = 16'($urandom);
               if (e == 16'hFFFF || e == 16'hFFF0) e = 16'h0A5A;
            end
            tbl[63-16*i -: 16] = e;
         end
         run_pass(tbl, 16'($urandom & $urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
         compare_pass($sformatf("rnd%0d", p));
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
